// File: rtl/magic_nor_if.sv
// ---------------------------------------------------------------------------
// magic_nor_if : host <-> MAGIC NOR executor program/vector/result bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface magic_nor_if #(
  parameter int N_IN = 8,
  parameter int CW   = 5,
  parameter int PW   = 6,
  parameter int AW   = 5
);
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [3*CW-1:0] prog_data;
  logic [PW-1:0]   prog_len;
  logic [CW-1:0]   out_idx;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] x;
  logic            out_valid;
  logic            out_ready;
  logic            z;
  logic            err;
  logic            busy;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, out_idx, in_valid, x, out_ready,
    input  in_ready, out_valid, z, err, busy
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, out_idx, in_valid, x, out_ready,
    output in_ready, out_valid, z, err, busy
  );
endinterface

`default_nettype wire

// File: rtl/magic_nor_executor.sv
// ---------------------------------------------------------------------------
// magic_nor_executor : serial INIT/EVAL executor for MAGIC NOR micro-programs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module magic_nor_executor #(
  parameter int N_IN    = 8,
  parameter int N_CELLS = 32,
  parameter int N_OPS   = 32,
  parameter int CW      = $clog2(N_CELLS),
  parameter int PW      = $clog2(N_OPS) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  magic_nor_if.slave bus
);
  localparam int AW = (N_OPS > 1) ? $clog2(N_OPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_INIT = 3'd2,
    S_EVAL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state;
  logic [N_CELLS-1:0] cells;
  logic [3*CW-1:0] prog_mem [N_OPS];
  logic [PW-1:0]   len;
  logic [PW-1:0]   pc;
  logic [CW-1:0]   oidx;
  logic            out_valid;
  logic            z;
  logic            err;

  logic [CW-1:0]   src_a;
  logic [CW-1:0]   src_b;
  logic [CW-1:0]   dst;
  logic [PW-1:0]   pc_next;
  logic [PW-1:0]   len_clamped;
  logic            op_bad;
  logic            oidx_bad;

  assign {src_a, src_b, dst} = prog_mem[pc[AW-1:0]];
  assign pc_next     = pc + PW'(1);
  assign len_clamped = (bus.prog_len > PW'(N_OPS)) ? PW'(N_OPS) : bus.prog_len;

  // Inputs are read-only; every index must also land inside the row.
  assign op_bad   = (32'(dst) < 32'(N_IN)) || (32'(dst) >= 32'(N_CELLS)) ||
                    (32'(src_a) >= 32'(N_CELLS)) || (32'(src_b) >= 32'(N_CELLS));
  assign oidx_bad = (32'(oidx) >= 32'(N_CELLS));

  always_ff @(posedge clk) begin
    if (bus.prog_we && state == S_IDLE) begin
      prog_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cells     <= '0;
      len       <= '0;
      pc        <= '0;
      oidx      <= '0;
      out_valid <= 1'b0;
      z         <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            cells[N_IN-1:0] <= bus.x;
            len             <= len_clamped;
            oidx            <= bus.out_idx;
            pc              <= '0;
            state           <= S_LOAD;
          end
        end
        S_LOAD: begin
          state <= (len == '0) ? S_DONE : S_INIT;
        end
        S_INIT: begin
          if (op_bad) begin
            err   <= 1'b1;
            state <= S_DONE;
          end else begin
            cells[dst] <= 1'b1;
            state      <= S_EVAL;
          end
        end
        S_EVAL: begin
          // MAGIC only switches 1->0, so the NOR is folded onto the preset 1.
          cells[dst] <= cells[dst] & ~(cells[src_a] | cells[src_b]);
          pc         <= pc_next;
          state      <= (pc_next == len) ? S_DONE : S_INIT;
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (err || oidx_bad) begin
              err <= 1'b1;
              z   <= 1'b0;
            end else begin
              z <= cells[oidx];
            end
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid;
  assign bus.z         = z;
  assign bus.err       = err;

endmodule

`default_nettype wire

// File: tb/tb_magic_nor_executor.sv
// ---------------------------------------------------------------------------
// tb_magic_nor_executor : directed self-checking bench for magic_nor_executor
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_magic_nor_executor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  magic_nor_if #(.N_IN(8), .CW(5), .PW(6), .AW(5)) bus ();

  magic_nor_executor #(.N_IN(8), .N_CELLS(32), .N_OPS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 8-input AND: NOT each input, NOR pairs, then a NOT/NOR tree into cell 28.
  int and_prog [21][3] = '{
    '{0, 0, 8},   '{1, 1, 9},   '{2, 2, 10},  '{3, 3, 11},
    '{4, 4, 12},  '{5, 5, 13},  '{6, 6, 14},  '{7, 7, 15},
    '{8, 9, 16},  '{10, 11, 17}, '{12, 13, 18}, '{14, 15, 19},
    '{16, 16, 20}, '{17, 17, 21}, '{20, 21, 22}, '{18, 18, 23},
    '{19, 19, 24}, '{23, 24, 25}, '{22, 22, 26}, '{25, 25, 27},
    '{26, 27, 28}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_op(input logic [4:0] addr, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = {a, b, d};
    step();
    bus.prog_we = 1'b0;
  endtask

  // Starts one run, waits (bounded) for out_valid and completes the handshake if out_ready.
  task automatic run(input logic [7:0] xv, input logic [5:0] l, input logic [4:0] oi,
                     output logic zo, output logic eo, output int lat);
    bus.x        = xv;
    bus.prog_len = l;
    bus.out_idx  = oi;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.prog_we  = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      step();
      lat++;
    end
    check("run_out_valid", bus.out_valid, 1);
    zo = bus.z;
    eo = bus.err;
    if (bus.out_ready) begin
      step();
      check("hs_in_ready", bus.in_ready, 1);
    end
  endtask

  initial begin
    logic       zr;
    logic       er;
    int         lat;
    logic [7:0] cur;
    logic [7:0] nx;

    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.out_idx   = '0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_z", bus.z, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);

    for (int k = 0; k < 21; k++) begin
      write_op(5'(k), 5'(and_prog[k][0]), 5'(and_prog[k][1]), 5'(and_prog[k][2]));
    end
    for (int k = 21; k < 32; k++) begin
      write_op(5'(k), 5'd0, 5'd0, 5'd29);
    end

    run(8'hFF, 6'd21, 5'd28, zr, er, lat);
    check("and_ff_z", zr, 1);
    check("and_ff_err", er, 0);
    check("and_ff_lat", lat, 44);
    run(8'hFE, 6'd21, 5'd28, zr, er, lat);
    check("and_fe_z", zr, 0);
    run(8'h7F, 6'd21, 5'd28, zr, er, lat);
    check("and_7f_z", zr, 0);

    run(8'h08, 6'd0, 5'd3, zr, er, lat);
    check("len0_z1", zr, 1);
    check("len0_lat", lat, 2);
    run(8'h00, 6'd0, 5'd3, zr, er, lat);
    check("len0_z0", zr, 0);

    // len above program depth runs all 32 slots.
    run(8'hFF, 6'd40, 5'd28, zr, er, lat);
    check("clamp_z", zr, 1);
    check("clamp_lat", lat, 66);

    write_op(5'd0, 5'd1, 5'd2, 5'd5);
    run(8'hFF, 6'd1, 5'd5, zr, er, lat);
    check("illegal_err", er, 1);
    check("illegal_z", zr, 0);
    check("illegal_err_cleared", bus.err, 0);

    // Restore op 0 in the same cycle the run is accepted.
    bus.prog_we   = 1'b1;
    bus.prog_addr = 5'd0;
    bus.prog_data = {5'd0, 5'd0, 5'd8};
    run(8'hFF, 6'd21, 5'd28, zr, er, lat);
    check("restore_z", zr, 1);
    check("restore_err", er, 0);

    bus.out_ready = 1'b0;
    run(8'hFF, 6'd21, 5'd28, zr, er, lat);
    for (int i = 0; i < 10; i++) begin
      bus.prog_we   = i[0];
      bus.prog_addr = 5'd20;
      bus.prog_data = {5'd0, 5'd0, 5'd28};
      step();
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_z", bus.z, 1);
      check("stall_in_ready", bus.in_ready, 0);
    end
    bus.prog_we   = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("stall_release_valid", bus.out_valid, 0);
    check("stall_release_ready", bus.in_ready, 1);
    run(8'hFE, 6'd21, 5'd28, zr, er, lat);
    check("stall_prog_fe", zr, 0);
    run(8'hFF, 6'd21, 5'd28, zr, er, lat);
    check("stall_prog_ff", zr, 1);

    // Abort during EVAL of op 5: accept edge plus 12 edges.
    bus.x        = 8'hFF;
    bus.prog_len = 6'd21;
    bus.out_idx  = 5'd28;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (12) step();
    check("abort_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_z", bus.z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run(8'hFF, 6'd21, 5'd28, zr, er, lat);
    check("abort_rerun_z", zr, 1);
    check("abort_rerun_lat", lat, 44);

    // Back-to-back: accept one cycle after each handshake, 45 cycles per result.
    bus.out_ready = 1'b1;
    bus.prog_len  = 6'd21;
    bus.out_idx   = 5'd28;
    cur           = 8'hFF;
    bus.x         = cur;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
        step();
        lat++;
      end
      check("b2b_lat", lat, 45);
      check("b2b_z", bus.z, {31'd0, (cur == 8'hFF)});
      case (i % 3)
        0:       nx = 8'hFF;
        1:       nx = ~(8'h01 << (i % 8));
        default: nx = 8'($urandom);
      endcase
      cur   = nx;
      bus.x = nx;
      if (i == 199) bus.in_valid = 1'b0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
